sigma_delta_decoder: RTL and testbench

Receive-side counterpart of the sigma-delta modulator: accepts the 1-bit sigma-delta bitstream, one bit per `clk` cycle, and recovers the multi-bit input value. Recovery uses a CIC (sinc^ORDER) decimation filter with ratio R = 2^DECIM_LOG2. Each filter output is scaled and saturated to VALUE_WIDTH bits and delivered through a one-entry valid/ready output register. The block sits after the modulator, or after any 1-bit bitstream source, in loopback and ADC-style datapaths.

---
 rtl/sigma_delta_decoder.sv | 126 ++++++++++++
 tb/tb_sigma_delta_decoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sigma_delta_decoder.sv
// sigma_delta_decoder: CIC (sinc^ORDER) decimator that recovers a VALUE_WIDTH-bit
// sample from a 1-bit sigma-delta bitstream, with a one-entry valid/ready output
// register and a sticky overrun flag for samples dropped under backpressure.
module sigma_delta_decoder #(
    parameter int VALUE_WIDTH = 8,
    parameter int ORDER       = 2,
    parameter int DECIM_LOG2  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   sigma_delta,
    output logic [VALUE_WIDTH-1:0] value,
    output logic                   value_valid,
    input  logic                   value_ready,
    output logic                   overrun
);

    localparam int ACC_W = ORDER * DECIM_LOG2 + 1;
    localparam int SHIFT = ORDER * DECIM_LOG2 - VALUE_WIDTH;
    localparam int SET_W = $clog2(ORDER + 1);

    localparam logic [DECIM_LOG2-1:0] PHASE_LAST = '1;
    localparam logic [SET_W-1:0]      SETTLED    = SET_W'(ORDER);

    logic [ACC_W-1:0]       integ   [ORDER];
    logic [ACC_W-1:0]       dly     [ORDER];
    logic [ACC_W-1:0]       comb_in [ORDER];
    logic [ACC_W-1:0]       comb_sum;
    logic [ACC_W-1:0]       shifted;
    logic [VALUE_WIDTH-1:0] scaled;
    logic [DECIM_LOG2-1:0]  phase;
    logic [SET_W-1:0]       settle;
    logic                   strobe;
    logic                   settled;
    logic                   load_ok;

    assign strobe  = enable && (phase == PHASE_LAST);
    assign settled = (settle == SETTLED);
    assign load_ok = strobe && settled;

    // Comb chain evaluated in a single cycle; each stage subtracts its delayed input.
    always_comb begin : comb_chain
        logic [ACC_W-1:0] x;
        x = integ[ORDER-1];
        for (int k = 0; k < ORDER; k++) begin
            comb_in[k] = x;
            x          = x - dly[k];
        end
        comb_sum = x;
    end

    // Scale the comb result down to VALUE_WIDTH and saturate full scale to all-ones.
    always_comb begin
        shifted = comb_sum >> SHIFT;
        if (|(shifted >> VALUE_WIDTH)) begin
            scaled = '1;
        end else begin
            scaled = shifted[VALUE_WIDTH-1:0];
        end
    end

    // Integrator cascade; modular wrap-around is harmless because the combs undo it.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            for (int k = 0; k < ORDER; k++) begin
                integ[k] <= '0;
            end
        end else begin
            integ[0] <= integ[0] + ACC_W'(sigma_delta);
            for (int k = 1; k < ORDER; k++) begin
                integ[k] <= integ[k] + integ[k-1];
            end
        end
    end

    // Comb delay registers capture their stage input on each strobe.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            for (int k = 0; k < ORDER; k++) begin
                dly[k] <= '0;
            end
        end else if (strobe) begin
            for (int k = 0; k < ORDER; k++) begin
                dly[k] <= comb_in[k];
            end
        end
    end

    // Decimation phase counter, free-running modulo R while enabled.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    // Settle counter: the first ORDER strobes carry filter start-up transients.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            settle <= '0;
        end else if (strobe && !settled) begin
            settle <= settle + 1'b1;
        end
    end

    // Output register with same-cycle replace on accept; drops set sticky overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            value       <= '0;
            value_valid <= 1'b0;
            overrun     <= 1'b0;
        end else if (load_ok) begin
            if (!value_valid || value_ready) begin
                value       <= scaled;
                value_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (value_valid && value_ready) begin
            value_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sigma_delta_decoder.sv
// tb_sigma_delta_decoder: directed tests for the CIC sigma-delta decoder at its
// default parameters (R=16, ORDER=2, 8-bit output).
module tb_sigma_delta_decoder;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       sigma_delta;
    logic [7:0] value;
    logic       value_valid;
    logic       value_ready;
    logic       overrun;

    int total;
    int bad;

    sigma_delta_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .sigma_delta (sigma_delta),
        .value       (value),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .overrun     (overrun)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // One clock: inputs already set at a negedge, outputs sampled at the next negedge.
    task automatic step(input logic sd);
        sigma_delta = sd;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        step(1'b0);
        reset  = 1'b0;
    endtask

    // Steps with ones until value_valid or the limit; returns cycles taken.
    task automatic wait_valid(input int limit, output int cyc);
        cyc = 0;
        while (!value_valid && cyc < limit) begin
            step(1'b1);
            cyc++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (value !== 8'd0) begin bad++; $display("FAIL reset_value got=%0d want=0", value); end
        total++; if (value_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", value_valid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    endtask

    task automatic test_ones();
        int first = 0;
        int n = 0;
        do_reset();
        enable = 1'b1; value_ready = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            step(1'b1);
            if (value_valid) begin
                n++;
                if (first == 0) first = i;
                total++;
                if (value !== 8'd255) begin bad++; $display("FAIL ones_value cyc=%0d got=%0d want=255", i, value); end
            end
        end
        total++; if (first !== 48) begin bad++; $display("FAIL ones_first_valid got=%0d want=48", first); end
        total++; if (n !== 10) begin bad++; $display("FAIL ones_count got=%0d want=10", n); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ones_overrun got=%b want=0", overrun); end
    endtask

    task automatic test_zeros_alt();
        int nz = 0;
        int na = 0;
        int nchk = 0;
        do_reset();
        enable = 1'b1; value_ready = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            step(1'b0);
            if (value_valid) begin
                nz++;
                total++;
                if (value !== 8'd0) begin bad++; $display("FAIL zeros_value cyc=%0d got=%0d want=0", i, value); end
            end
        end
        total++; if (nz !== 2) begin bad++; $display("FAIL zeros_count got=%0d want=2", nz); end
        for (int i = 0; i < 160; i++) begin
            step((i % 2) == 0);
            if (value_valid) begin
                na++;
                if (na > 2) begin
                    nchk++;
                    total++;
                    if (value !== 8'd128) begin bad++; $display("FAIL alt_value idx=%0d got=%0d want=128", i, value); end
                end
            end
        end
        total++; if (nchk !== 8) begin bad++; $display("FAIL alt_count got=%0d want=8", nchk); end
    endtask

    task automatic test_quarter();
        int n = 0;
        do_reset();
        enable = 1'b1; value_ready = 1'b1;
        for (int i = 0; i < 640; i++) begin
            step((i % 4) == 0);
            if (value_valid) begin
                n++;
                total++;
                if (value !== 8'd64) begin bad++; $display("FAIL quarter_value cyc=%0d got=%0d want=64", i + 1, value); end
            end
        end
        total++; if (n !== 38) begin bad++; $display("FAIL quarter_count got=%0d want=38", n); end
    endtask

    task automatic test_loopback();
        int acc = 0;
        int n = 0;
        logic b;
        do_reset();
        enable = 1'b1; value_ready = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            acc += 100;
            if (acc >= 256) begin b = 1'b1; acc -= 256; end
            else b = 1'b0;
            step(b);
            if (value_valid) begin
                n++;
                total++;
                if (value < 8'd99 || value > 8'd102) begin
                    bad++; $display("FAIL loopback_value cyc=%0d got=%0d want=99..102", i + 1, value);
                end
            end
        end
        total++; if (n !== 123) begin bad++; $display("FAIL loopback_count got=%0d want=123", n); end
    endtask

    task automatic test_backpressure();
        int cyc;
        do_reset();
        enable = 1'b1; value_ready = 1'b1;
        wait_valid(100, cyc);
        total++; if (cyc !== 48) begin bad++; $display("FAIL bp_first_valid got=%0d want=48", cyc); end
        value_ready = 1'b0;
        for (int i = 0; i < 40; i++) step(1'b1);
        total++; if (value !== 8'd255) begin bad++; $display("FAIL bp_hold_value got=%0d want=255", value); end
        total++; if (value_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid got=%b want=1", value_valid); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL bp_overrun got=%b want=1", overrun); end
        value_ready = 1'b1;
        step(1'b1);
        total++; if (value_valid !== 1'b0) begin bad++; $display("FAIL bp_transfer_valid got=%b want=0", value_valid); end
        wait_valid(32, cyc);
        total++; if (cyc !== 7) begin bad++; $display("FAIL bp_resume_cycles got=%0d want=7", cyc); end
        total++; if (value !== 8'd255) begin bad++; $display("FAIL bp_resume_value got=%0d want=255", value); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL bp_overrun_sticky got=%b want=1", overrun); end
    endtask

    // Continues from the backpressure state so the reset has nonzero outputs to clear.
    task automatic test_reset_mid();
        int cyc;
        value_ready = 1'b0;
        for (int i = 0; i < 25; i++) step(1'b1);
        total++; if (value_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_valid got=%b want=1", value_valid); end
        reset = 1'b1;
        step(1'b1);
        total++; if (value !== 8'd0) begin bad++; $display("FAIL rst_mid_value got=%0d want=0", value); end
        total++; if (value_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b want=0", value_valid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_mid_overrun got=%b want=0", overrun); end
        reset = 1'b0; value_ready = 1'b1;
        wait_valid(100, cyc);
        total++; if (cyc !== 48) begin bad++; $display("FAIL rst_mid_first_valid got=%0d want=48", cyc); end
    endtask

    task automatic test_enable_drop();
        int cyc;
        do_reset();
        enable = 1'b1; value_ready = 1'b0;
        wait_valid(100, cyc);
        total++; if (cyc !== 48) begin bad++; $display("FAIL en_first_valid got=%0d want=48", cyc); end
        enable = 1'b0;
        for (int i = 0; i < 20; i++) step(1'b1);
        total++; if (value_valid !== 1'b1) begin bad++; $display("FAIL en_pending_valid got=%b want=1", value_valid); end
        total++; if (value !== 8'd255) begin bad++; $display("FAIL en_pending_value got=%0d want=255", value); end
        value_ready = 1'b1;
        step(1'b1);
        total++; if (value_valid !== 1'b0) begin bad++; $display("FAIL en_accept_valid got=%b want=0", value_valid); end
        enable = 1'b1;
        wait_valid(100, cyc);
        total++; if (cyc !== 48) begin bad++; $display("FAIL en_resettle got=%0d want=48", cyc); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL en_overrun got=%b want=0", overrun); end
    endtask

    // Test sequence.
    initial begin
        total = 0; bad = 0;
        clk = 1'b0; reset = 1'b1; enable = 1'b0; sigma_delta = 1'b0; value_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_ones();
        test_zeros_alt();
        test_quarter();
        test_loopback();
        test_backpressure();
        test_reset_mid();
        test_enable_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
